alu_addsub_dispatch: RTL and testbench
======================================

# alu_addsub_dispatch

- Front end for the sign-magnitude add/subtract unit.
- Accepts signed two's-complement add/sub requests over a valid/ready channel.
- Converts the operands to magnitude plus a 4-bit sign control code and issues them with a one-cycle `alu_start` pulse.
- Waits for `alu_finish`, then converts the returned magnitude/sign pair back to two's complement with an overflow flag. One operation is in flight at a time.

## Interface
Parameters:
- `TIMEOUT`, 64: cycles in WAIT without `alu_finish` before an error response. Range 1..65535.
- `TW`, `$clog2(TIMEOUT+1)`: width of the timeout counter.

Ports:
- `clock`  in  1  Single clock; everything is rising-edge.
- `reset`  in  1  Asynchronous, active-low reset.
- `req_valid`  in  1  Request present.
- `req_ready`  out  1  High only in IDLE.
- `req_a`  in  32  Signed operand A.
- `req_b`  in  32  Signed operand B.
- `req_sub`  in  1  0 = A+B, 1 = A−B.
- `rsp_valid`  out  1  Response present.
- `rsp_ready`  in  1  Consumer accepts the response.
- `rsp_result`  out  32  Two's-complement result; low 32 bits of the exact sum.
- `rsp_ovf`  out  1  Exact sum is outside −2^31..2^31−1.
- `rsp_err`  out  1  Operation timed out.
- `alu_start`  out  1  One-cycle issue pulse to the unit.
- `alu_control`  out  4  1000 PP, 1001 PN, 1010 NP, 1011 NN.
- `alu_A`  out  32  Magnitude of A.
- `alu_B`  out  32  Magnitude of the effective B.
- `alu_finish`  in  1  Unit result valid this cycle.
- `alu_C`  in  32  Result magnitude.
- `alu_sign`  in  1  Result sign (1 = negative).

## Operation
States and transitions:
- **IDLE**: `req_ready`=1. On `req_valid`, register the operands and go to ISSUE.
- **ISSUE**: `alu_start`=1 for exactly this cycle. Next state is WAIT.
- **WAIT**: on `alu_finish`, capture `alu_C` and `alu_sign` and go to RESP. If the timeout counter reaches `TIMEOUT`, go to RESP with the error set.
- **RESP**: `rsp_valid`=1 and the response is held stable. On `rsp_ready`, go to IDLE.

Arithmetic:
- Effective B is `req_sub ? −req_b : req_b`, computed in 33 bits, so −(−2^31) = +2^31 with sign 0.
- A magnitude is |A| in 33 bits, truncated to 32. 2^31 fits unsigned.
- `alu_control` = {1, 0, sign(A), sign(effective B)}.
- Result value V = `alu_sign` ? −`alu_C` : `alu_C`, evaluated in 34 bits.
- `rsp_result` = V[31:0].
- `rsp_ovf` = 1 when `alu_sign`=0 and `alu_C` > 0x7FFFFFFF, or when `alu_sign`=1 and `alu_C` > 0x80000000.
- A negative zero (`alu_sign`=1, C=0) returns result 0 with `rsp_ovf`=0.

Outputs and conditions:
- `alu_control`, `alu_A` and `alu_B` are registered. They are stable from ISSUE through WAIT and hold their last value otherwise.
- `alu_finish` is ignored in IDLE, ISSUE and RESP. A late finish after a timeout is dropped.
- A timeout response has `rsp_err`=1, `rsp_result`=0 and `rsp_ovf`=0.

## Timing
- A request accepted at the edge of cycle t gives ISSUE in t+1 and WAIT from t+2.
- `alu_finish` sampled in cycle f gives `rsp_valid` in f+1. Minimum request-to-response latency is 3 cycles plus the unit latency.
- A response handshake in cycle r gives `req_ready`=1 in r+1. There is no request/response overlap.
- The timeout counter clears on entering WAIT and increments each WAIT cycle. The error response is raised after `TIMEOUT` cycles with no finish.
- If `alu_finish` arrives in the same cycle the counter reaches `TIMEOUT`, the finish wins.

Reset (`reset`=0, at any time, including mid-WAIT):
- State goes to IDLE.
- `req_ready`=1.
- `alu_start`, `rsp_valid`, `rsp_ovf`, `rsp_err` = 0.
- `rsp_result`, `alu_A`, `alu_B` = 0.
- `alu_control` = 4'b1000.
- The operation in flight is abandoned.

## Configuration
`ALU_DISPATCH_TIMEOUT_EN`:
- **Defined**: the timeout counter and `rsp_err` logic are built as described above.
- **Undefined**: the counter is removed, WAIT lasts until `alu_finish` with no limit, and `rsp_err` is tied to 0. `TIMEOUT` and `TW` are accepted but unused.

## Structure
- The shared package `alu_pkg` holds the control codes ADDPP/ADDPN/ADDNP/ADDNN as 4-bit localparams and the dispatch state enum (IDLE, ISSUE, WAIT, RESP).
- One combinational sub-module, `tc_sm_conv`, handles sign-magnitude conversion. It is instantiated twice:
  - signed to sign+magnitude, for A and for effective B;
  - sign+magnitude to signed plus overflow, for the result.
- The FSM, operand registers and timeout counter live in the top.

## Test plan
- a=5, b=3, sub=0; model returns C=8, sign 0 → `alu_control`=1000, A=5, B=3, `rsp_result`=8, ovf=0.
- a=5, b=−7, sub=0; model returns C=2, sign 1 → control 1001, B=7, `rsp_result`=0xFFFFFFFE.
- a=0x80000000, b=1, sub=1; model returns C=0x80000001, sign 1 → control 1011, A=0x80000000, `rsp_result`=0x7FFFFFFF, ovf=1.
- a=0, b=0x80000000, sub=1 → control 1000, B=0x80000000. Model returns C=0x80000000, sign 0 → ovf=1.
- Model never finishes, TIMEOUT=64 → `rsp_valid` 64 cycles after WAIT entry with err=1 and result 0. A finish one cycle later is ignored.
- `rsp_ready` held low 10 cycles while `req_valid` is high → response stable and `req_ready`=0 throughout. A reset pulse mid-WAIT returns IDLE, and a subsequent stray `alu_finish` produces no response.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared definitions for the sign-magnitude add/sub front end.
//               Control codes sent to the unit and the dispatch FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

  // Control codes: {1, 0, sign(A), sign(effective B)}
  localparam logic [3:0] ADDPP = 4'b1000;
  localparam logic [3:0] ADDPN = 4'b1001;
  localparam logic [3:0] ADDNP = 4'b1010;
  localparam logic [3:0] ADDNN = 4'b1011;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } dispatch_state_t;

endpackage
`default_nettype wire

// File: rtl/tc_sm_conv.sv
`default_nettype none
// ============================================================================
// Module      : tc_sm_conv
// Description : Combinational two's-complement <-> sign-magnitude converter.
//               Forward path: signed A and B (with optional negation of B)
//               to magnitudes plus a 4-bit control code.
//               Reverse path: magnitude/sign back to 32-bit two's complement
//               with an overflow flag.
// Ports       : a_i, b_i, sub_i     - signed operands and subtract select
//               a_mag_o, b_mag_o    - magnitudes of A and effective B
//               ctrl_o              - {1,0,sign(A),sign(effective B)}
//               c_i, c_sign_i       - result magnitude and sign
//               result_o, ovf_o     - two's-complement result, overflow
// Revision    : 1.0 - initial release
// ============================================================================
module tc_sm_conv
  import alu_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        sub_i,
  output logic [31:0] a_mag_o,
  output logic [31:0] b_mag_o,
  output logic [3:0]  ctrl_o,
  input  logic [31:0] c_i,
  input  logic        c_sign_i,
  output logic [31:0] result_o,
  output logic        ovf_o
);

  logic [32:0] w_a_ext;
  logic [32:0] w_a_mag;
  logic        w_a_neg;
  logic [32:0] w_b_ext;
  logic [32:0] w_b_eff;
  logic [32:0] w_b_mag;
  logic        w_b_neg;
  logic [33:0] w_c_ext;
  logic [33:0] w_v;
  logic        w_unused_msbs;

  // 33-bit arithmetic so that -(-2^31) is representable as +2^31.
  assign w_a_ext = {a_i[31], a_i};
  assign w_a_neg = a_i[31];
  assign w_a_mag = w_a_neg ? (33'd0 - w_a_ext) : w_a_ext;

  assign w_b_ext = {b_i[31], b_i};
  assign w_b_eff = sub_i ? (33'd0 - w_b_ext) : w_b_ext;
  assign w_b_neg = w_b_eff[32];
  assign w_b_mag = w_b_neg ? (33'd0 - w_b_eff) : w_b_eff;

  // Magnitudes never exceed 2^31, so the top bit is always zero.
  assign a_mag_o = w_a_mag[31:0];
  assign b_mag_o = w_b_mag[31:0];
  assign ctrl_o  = ADDPP | {2'b00, w_a_neg, w_b_neg};

  assign w_c_ext  = {2'b00, c_i};
  assign w_v      = c_sign_i ? (34'd0 - w_c_ext) : w_c_ext;
  assign result_o = w_v[31:0];
  // Negative range reaches -2^31, positive only 2^31-1; negative zero is fine.
  assign ovf_o    = c_sign_i ? (c_i > 32'h8000_0000) : (c_i > 32'h7FFF_FFFF);

  assign w_unused_msbs = ^{w_a_mag[32], w_b_mag[32], w_v[33:32]};

endmodule
`default_nettype wire

// File: rtl/alu_addsub_dispatch.sv
`default_nettype none
// ============================================================================
// Module      : alu_addsub_dispatch
// Description : Front end for the sign-magnitude add/subtract unit. Accepts
//               signed add/sub requests, issues magnitudes plus a control
//               code with a one-cycle start pulse, waits for the unit and
//               returns a two's-complement result with overflow flag.
//               One operation in flight at a time.
// Ports       : clock, reset (async, active low)
//               req_*  - request channel (valid/ready)
//               rsp_*  - response channel (valid/ready)
//               alu_*  - interface to the sign-magnitude unit
// Config      : ALU_DISPATCH_TIMEOUT_EN - build the WAIT timeout counter and
//               error response; otherwise WAIT is unbounded, rsp_err = 0.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_addsub_dispatch
  import alu_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int TW      = $clog2(TIMEOUT + 1)
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic        req_sub,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_ovf,
  output logic        rsp_err,
  output logic        alu_start,
  output logic [3:0]  alu_control,
  output logic [31:0] alu_A,
  output logic [31:0] alu_B,
  input  logic        alu_finish,
  input  logic [31:0] alu_C,
  input  logic        alu_sign
);

  dispatch_state_t state_q, state_d;

  logic [31:0] alu_a_q;
  logic [31:0] alu_b_q;
  logic [3:0]  alu_ctrl_q;
  logic [31:0] rsp_result_q;
  logic        rsp_ovf_q;
  logic        rsp_err_q;

  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [3:0]  w_ctrl;
  logic [31:0] w_res;
  logic        w_ovf;
  logic        w_timeout;

  logic [31:0] w_unused_res;
  logic        w_unused_ovf;
  logic [31:0] w_unused_amag;
  logic [31:0] w_unused_bmag;
  logic [3:0]  w_unused_ctrl;

  // Forward conversion of the live request operands.
  tc_sm_conv u_to_sm (
    .a_i      (req_a),
    .b_i      (req_b),
    .sub_i    (req_sub),
    .a_mag_o  (w_a_mag),
    .b_mag_o  (w_b_mag),
    .ctrl_o   (w_ctrl),
    .c_i      (32'd0),
    .c_sign_i (1'b0),
    .result_o (w_unused_res),
    .ovf_o    (w_unused_ovf)
  );

  // Reverse conversion of the unit's result, captured on alu_finish.
  tc_sm_conv u_to_tc (
    .a_i      (32'd0),
    .b_i      (32'd0),
    .sub_i    (1'b0),
    .a_mag_o  (w_unused_amag),
    .b_mag_o  (w_unused_bmag),
    .ctrl_o   (w_unused_ctrl),
    .c_i      (alu_C),
    .c_sign_i (alu_sign),
    .result_o (w_res),
    .ovf_o    (w_ovf)
  );

`ifdef ALU_DISPATCH_TIMEOUT_EN
  logic [TW-1:0] cnt_q;

  // A finish in the final counted cycle takes priority over the timeout.
  assign w_timeout = (state_q == WAIT) && !alu_finish &&
                     (cnt_q == TW'(TIMEOUT - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (state_q == ISSUE) begin
      cnt_q <= '0;
    end else if (state_q == WAIT) begin
      cnt_q <= cnt_q + TW'(1);
    end
  end
`else
  logic [TW-1:0] w_unused_cfg;
  assign w_unused_cfg = TW'(TIMEOUT);
  assign w_timeout    = 1'b0;
`endif

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (alu_finish || w_timeout) state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    req_ready = 1'b0;
    alu_start = 1'b0;
    rsp_valid = 1'b0;
    case (state_q)
      IDLE:    req_ready = 1'b1;
      ISSUE:   alu_start = 1'b1;
      RESP:    rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // Operand and response registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_ctrl_q   <= ADDPP;
      rsp_result_q <= '0;
      rsp_ovf_q    <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            alu_a_q    <= w_a_mag;
            alu_b_q    <= w_b_mag;
            alu_ctrl_q <= w_ctrl;
          end
        end
        WAIT: begin
          if (alu_finish) begin
            rsp_result_q <= w_res;
            rsp_ovf_q    <= w_ovf;
            rsp_err_q    <= 1'b0;
          end else if (w_timeout) begin
            rsp_result_q <= '0;
            rsp_ovf_q    <= 1'b0;
            rsp_err_q    <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign alu_A       = alu_a_q;
  assign alu_B       = alu_b_q;
  assign alu_control = alu_ctrl_q;
  assign rsp_result  = rsp_result_q;
  assign rsp_ovf     = rsp_ovf_q;
  assign rsp_err     = rsp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_addsub_dispatch.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_addsub_dispatch
// Description : Directed self-checking bench for alu_addsub_dispatch. Plays
//               the role of the sign-magnitude unit with hand-computed
//               results; drives and samples on the falling clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_addsub_dispatch;

  localparam int TIMEOUT = 64;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic        req_sub = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_result;
  logic        rsp_ovf;
  logic        rsp_err;
  logic        alu_start;
  logic [3:0]  alu_control;
  logic [31:0] alu_A;
  logic [31:0] alu_B;
  logic        alu_finish = 1'b0;
  logic [31:0] alu_C = '0;
  logic        alu_sign = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  alu_addsub_dispatch #(.TIMEOUT(TIMEOUT)) u_dut (
    .clock       (clock),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_sub     (req_sub),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_result  (rsp_result),
    .rsp_ovf     (rsp_ovf),
    .rsp_err     (rsp_err),
    .alu_start   (alu_start),
    .alu_control (alu_control),
    .alu_A       (alu_A),
    .alu_B       (alu_B),
    .alu_finish  (alu_finish),
    .alu_C       (alu_C),
    .alu_sign    (alu_sign)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  // Full transaction with a one-cycle unit latency; optional response stall.
  task automatic run_op(input string name,
                        input logic [31:0] a, input logic [31:0] b, input logic sub,
                        input logic [3:0] ectrl, input logic [31:0] ea, input logic [31:0] eb,
                        input logic [31:0] c, input logic s,
                        input logic [31:0] eres, input logic eovf, input int stall);
    check({name, ".ready_idle"}, req_ready, 1'b1);
    req_a = a; req_b = b; req_sub = sub; req_valid = 1'b1;
    tick();
    // Operands must already be registered; scramble the request bus.
    req_valid = (stall > 0);
    req_a = ~a; req_b = ~b; req_sub = ~sub;
    check({name, ".start"}, alu_start, 1'b1);
    check({name, ".ctrl"}, alu_control, ectrl);
    check({name, ".A"}, alu_A, ea);
    check({name, ".B"}, alu_B, eb);
    tick();
    check({name, ".start_pulse"}, alu_start, 1'b0);
    check({name, ".B_wait"}, alu_B, eb);
    alu_finish = 1'b1; alu_C = c; alu_sign = s;
    tick();
    alu_finish = 1'b0; alu_C = 32'hDEAD_BEEF; alu_sign = ~s;
    check({name, ".rsp_valid"}, rsp_valid, 1'b1);
    check({name, ".result"}, rsp_result, eres);
    check({name, ".ovf"}, rsp_ovf, eovf);
    check({name, ".err"}, rsp_err, 1'b0);
    for (int i = 0; i < stall; i++) begin
      tick();
      check({name, ".stall_valid"}, rsp_valid, 1'b1);
      check({name, ".stall_result"}, rsp_result, eres);
      check({name, ".stall_ready"}, req_ready, 1'b0);
    end
    rsp_ready = 1'b1; req_valid = 1'b0;
    tick();
    rsp_ready = 1'b0;
    check({name, ".rsp_done"}, rsp_valid, 1'b0);
    check({name, ".ready_back"}, req_ready, 1'b1);
  endtask

  initial begin
    tick();
    tick();
    check("rst.req_ready", req_ready, 1'b1);
    check("rst.rsp_valid", rsp_valid, 1'b0);
    check("rst.alu_start", alu_start, 1'b0);
    check("rst.ctrl", alu_control, 4'b1000);
    check("rst.A", alu_A, 32'd0);
    check("rst.B", alu_B, 32'd0);
    check("rst.result", rsp_result, 32'd0);
    check("rst.ovf", rsp_ovf, 1'b0);
    check("rst.err", rsp_err, 1'b0);
    reset = 1'b1;
    tick();

    //      name    a             b             sub   ctrl     A             B             C             sign  result        ovf  stall
    run_op("pp",    32'd5,        32'd3,        1'b0, 4'b1000, 32'd5,        32'd3,        32'd8,        1'b0, 32'd8,        1'b0, 10);
    run_op("pn",    32'd5,        32'hFFFFFFF9, 1'b0, 4'b1001, 32'd5,        32'd7,        32'd2,        1'b1, 32'hFFFFFFFE, 1'b0, 0);
    run_op("nn",    32'h80000000, 32'd1,        1'b1, 4'b1011, 32'h80000000, 32'd1,        32'h80000001, 1'b1, 32'h7FFFFFFF, 1'b1, 0);
    run_op("negmn", 32'd0,        32'h80000000, 1'b1, 4'b1000, 32'd0,        32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 1'b1, 0);
    run_op("nzero", 32'd3,        32'd3,        1'b1, 4'b1001, 32'd3,        32'd3,        32'd0,        1'b1, 32'd0,        1'b0, 0);
    run_op("minok", 32'hFFFFFFFF, 32'h7FFFFFFF, 1'b1, 4'b1011, 32'd1,        32'h7FFFFFFF, 32'h80000000, 1'b1, 32'h80000000, 1'b0, 0);
    run_op("np",    32'hFFFFFFF6, 32'd4,        1'b0, 4'b1010, 32'd10,       32'd4,        32'd6,        1'b1, 32'hFFFFFFFA, 1'b0, 0);

`ifdef ALU_DISPATCH_TIMEOUT_EN
    // Finish in the last counted WAIT cycle beats the timeout.
    req_a = 32'd1; req_b = 32'd10; req_sub = 1'b1; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    repeat (TIMEOUT) tick();
    check("race.no_rsp_yet", rsp_valid, 1'b0);
    alu_finish = 1'b1; alu_C = 32'd9; alu_sign = 1'b1;
    tick();
    alu_finish = 1'b0;
    check("race.valid", rsp_valid, 1'b1);
    check("race.err", rsp_err, 1'b0);
    check("race.result", rsp_result, 32'hFFFFFFF7);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // No finish: error response TIMEOUT cycles after entering WAIT.
    req_a = 32'd1; req_b = 32'd2; req_sub = 1'b0; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    repeat (TIMEOUT) tick();
    check("tmo.early", rsp_valid, 1'b0);
    tick();
    check("tmo.valid", rsp_valid, 1'b1);
    check("tmo.err", rsp_err, 1'b1);
    check("tmo.result", rsp_result, 32'd0);
    check("tmo.ovf", rsp_ovf, 1'b0);
    alu_finish = 1'b1; alu_C = 32'd5; alu_sign = 1'b0;
    tick();
    alu_finish = 1'b0;
    check("tmo.late_result", rsp_result, 32'd0);
    check("tmo.late_err", rsp_err, 1'b1);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("tmo.ready_back", req_ready, 1'b1);
`else
    // No timeout built: WAIT persists until the unit finishes.
    begin
      logic seen;
      seen = 1'b0;
      req_a = 32'd1; req_b = 32'd2; req_sub = 1'b0; req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      repeat (TIMEOUT + 40) begin
        tick();
        seen = seen | rsp_valid;
      end
      check("notmo.no_rsp", seen, 1'b0);
      alu_finish = 1'b1; alu_C = 32'd3; alu_sign = 1'b0;
      tick();
      alu_finish = 1'b0;
      check("notmo.valid", rsp_valid, 1'b1);
      check("notmo.err", rsp_err, 1'b0);
      check("notmo.result", rsp_result, 32'd3);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
    end
`endif

    // Reset mid-WAIT abandons the operation; a stray finish is dropped.
    req_a = 32'd10; req_b = 32'd20; req_sub = 1'b0; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    check("mid.A", alu_A, 32'd10);
    tick();
    reset = 1'b0;
    tick();
    check("mid.ready", req_ready, 1'b1);
    check("mid.ctrl", alu_control, 4'b1000);
    check("mid.A_rst", alu_A, 32'd0);
    check("mid.B_rst", alu_B, 32'd0);
    reset = 1'b1;
    alu_finish = 1'b1; alu_C = 32'd30; alu_sign = 1'b0;
    tick();
    alu_finish = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("mid.no_rsp", rsp_valid, 1'b0);
      check("mid.idle", req_ready, 1'b1);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
